// File: rtl/hdmi_pkg.sv
// rtl/hdmi_pkg.sv - shared HDMI link supervisor state encodings, widths and timing defaults
package hdmi_pkg;

  typedef enum logic [2:0] {
    ST_RESET     = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_QUALIFY   = 3'd2,
    ST_UP        = 3'd3,
    ST_FAIL      = 3'd4,
    ST_BACKOFF   = 3'd5
  } hdmi_state_t;

  localparam int STATE_W  = 3;
  localparam int STATUS_W = 8;

  localparam int DEF_RESET_CYCLES      = 64;
  localparam int DEF_LOCK_TIMEOUT_LOG2 = 20;
  localparam int DEF_STABLE_CYCLES     = 4096;
  localparam int DEF_LOSS_LOG2         = 20;
  localparam int DEF_BACKOFF_MIN_LOG2  = 10;
  localparam int DEF_BACKOFF_MAX_LOG2  = 20;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [STATUS_W-1:0] sat_inc8(input logic [STATUS_W-1:0] v);
    return (v == {STATUS_W{1'b1}}) ? v : v + STATUS_W'(1);
  endfunction

endpackage

// File: rtl/sync2.sv
// rtl/sync2.sv - two-flop synchroniser for a single asynchronous level
module sync2 (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/hdmi_link_supervisor.sv
// rtl/hdmi_link_supervisor.sv - TMDS decoder reset sequencing, link qualification,
// loss detection and exponential retry backoff
module hdmi_link_supervisor
  import hdmi_pkg::*;
#(
  parameter int RESET_CYCLES      = DEF_RESET_CYCLES,
  parameter int LOCK_TIMEOUT_LOG2 = DEF_LOCK_TIMEOUT_LOG2,
  parameter int STABLE_CYCLES     = DEF_STABLE_CYCLES,
  parameter int LOSS_LOG2         = DEF_LOSS_LOG2,
  parameter int BACKOFF_MIN_LOG2  = DEF_BACKOFF_MIN_LOG2,
  parameter int BACKOFF_MAX_LOG2  = DEF_BACKOFF_MAX_LOG2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                hdmi_valid_in,
  input  logic                hdmi_locked_in,
  input  logic                vsync_in,
  input  logic                user_reset,
  output logic                hdmi_reset,
  output logic                link_up,
  output logic [STATE_W-1:0]  state,
  output logic [STATUS_W-1:0] retry_count,
  output logic [STATUS_W-1:0] frame_count
);

  // One shared counter serves the reset pulse, lock timeout, stability run and backoff wait.
  localparam int CNT_W = max_int(max_int(LOCK_TIMEOUT_LOG2, BACKOFF_MAX_LOG2),
                                 max_int($clog2(RESET_CYCLES), $clog2(STABLE_CYCLES))) + 1;
  localparam int EXP_W = $clog2(BACKOFF_MAX_LOG2 + 1);

  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'((64'd1 << LOCK_TIMEOUT_LOG2) - 64'd1);
  localparam logic [EXP_W-1:0] EXP_MIN     = EXP_W'(BACKOFF_MIN_LOG2);
  localparam logic [EXP_W-1:0] EXP_MAX     = EXP_W'(BACKOFF_MAX_LOG2);

  logic valid_s;
  logic locked_s;
  logic vsync_s;
  logic vsync_d;

  sync2 u_sync_valid  (.clk(clk), .reset_n(reset_n), .d(hdmi_valid_in),  .q(valid_s));
  sync2 u_sync_locked (.clk(clk), .reset_n(reset_n), .d(hdmi_locked_in), .q(locked_s));
  sync2 u_sync_vsync  (.clk(clk), .reset_n(reset_n), .d(vsync_in),       .q(vsync_s));

  hdmi_state_t          st;
  logic [CNT_W-1:0]     cnt;
  logic [LOSS_LOG2-1:0] bucket;
  logic [EXP_W-1:0]     bo_exp;
  logic [EXP_W-1:0]     bo_cur;
  logic [CNT_W-1:0]     bo_last;

  // bo_cur freezes the exponent in force before FAIL bumped bo_exp.
  assign bo_last = (CNT_W'(1) << bo_cur) - CNT_W'(1);
  assign state   = st;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      st          <= ST_RESET;
      hdmi_reset  <= 1'b1;
      link_up     <= 1'b0;
      retry_count <= '0;
      cnt         <= '0;
      bucket      <= '0;
      bo_exp      <= EXP_MIN;
      bo_cur      <= EXP_MIN;
    end else if (user_reset) begin
      st         <= ST_RESET;
      hdmi_reset <= 1'b1;
      link_up    <= 1'b0;
      cnt        <= '0;
      bucket     <= '0;
    end else begin
      case (st)
        ST_RESET: begin
          if (cnt == RST_LAST) begin
            st         <= ST_WAIT_LOCK;
            hdmi_reset <= 1'b0;
            cnt        <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_WAIT_LOCK: begin
          if (locked_s) begin
            st  <= ST_QUALIFY;
            cnt <= '0;
          end else if (cnt == LOCK_LAST) begin
            st  <= ST_FAIL;
            cnt <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_QUALIFY: begin
          if (!locked_s) begin
            st  <= ST_FAIL;
            cnt <= '0;
          end else if (!valid_s) begin
            cnt <= '0;
          end else if (cnt == STABLE_LAST) begin
            st          <= ST_UP;
            link_up     <= 1'b1;
            cnt         <= '0;
            bucket      <= '0;
            retry_count <= '0;
            bo_exp      <= EXP_MIN;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_UP: begin
          if (!locked_s || (&bucket)) begin
            st      <= ST_FAIL;
            link_up <= 1'b0;
          end else if (!valid_s) begin
            bucket <= bucket + LOSS_LOG2'(1);
          end else if (bucket != '0) begin
            bucket <= bucket - LOSS_LOG2'(1);
          end
        end
        ST_FAIL: begin
          st          <= ST_BACKOFF;
          hdmi_reset  <= 1'b1;
          cnt         <= '0;
          retry_count <= sat_inc8(retry_count);
          bo_cur      <= bo_exp;
          bo_exp      <= (bo_exp == EXP_MAX) ? bo_exp : bo_exp + EXP_W'(1);
        end
        ST_BACKOFF: begin
          if (cnt == bo_last) begin
            st  <= ST_RESET;
            cnt <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          st         <= ST_RESET;
          hdmi_reset <= 1'b1;
          link_up    <= 1'b0;
          cnt        <= '0;
        end
      endcase
    end
  end

  // Frames are counted only while the link is qualified; the count survives link drops.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      vsync_d     <= 1'b0;
      frame_count <= '0;
    end else begin
      vsync_d <= vsync_s;
      if (st == ST_UP && vsync_d && !vsync_s) begin
        frame_count <= frame_count + STATUS_W'(1);
      end
    end
  end

endmodule

// File: doc/hdmi_link_supervisor.md
Name: hdmi_link_supervisor

Overview:
Sequences the TMDS decoder reset and supervises HDMI link health in the system clk domain. It replaces the ad-hoc invalid counter with an explicit state machine: reset pulse, lock wait, stability qualification, link-up monitoring, and exponential retry backoff. Its status outputs (link_up, state, retry_count, frame_count) feed the display module and the LED/UART debug paths.

Parameters:
RESET_CYCLES, 64, width of the hdmi_reset pulse in clk cycles (≥2).
LOCK_TIMEOUT_LOG2, 20, WAIT_LOCK times out after 2^LOCK_TIMEOUT_LOG2 cycles.
STABLE_CYCLES, 4096, consecutive valid+locked cycles required before link_up.
LOSS_LOG2, 20, leaky-bucket width; loss is declared when bit [LOSS_LOG2] would set.
BACKOFF_MIN_LOG2, 10, first backoff is 2^BACKOFF_MIN_LOG2 cycles.
BACKOFF_MAX_LOG2, 20, backoff exponent saturates here.

Ports:
clk  input  1  system clock (12 MHz)
reset_n  input  1  synchronous, active-low reset
hdmi_valid_in  input  1  decoder valid, hdmi_clk domain, asynchronous to clk
hdmi_locked_in  input  1  decoder PLL lock, asynchronous
vsync_in  input  1  stream vsync, asynchronous
user_reset  input  1  clk-domain request to restart the link
hdmi_reset  output  1  reset to the TMDS decoder, active-high
link_up  output  1  link qualified and healthy
state  output  3  current FSM state encoding
retry_count  output  8  failed attempts since the last link_up; saturates at 255
frame_count  output  8  falling vsync edges while link_up; wraps

Behaviour:
- Clock and reset:
  - Single clock clk.
  - Reset is synchronous and active-low on reset_n.
- Input synchronisers:
  - Each async input passes through a 2-flop synchroniser; all logic uses the synchronised copies (2-cycle latency).
  - Synchroniser flops reset to 0.
- Reset values: state=RESET, hdmi_reset=1, link_up=0, retry_count=0, frame_count=0, backoff exponent=BACKOFF_MIN_LOG2, all counters 0.
- States and encodings:
  - RESET (0): hdmi_reset=1 for exactly RESET_CYCLES cycles, then WAIT_LOCK. Counter clears on entry.
  - WAIT_LOCK (1): hdmi_reset=0. If locked, go to QUALIFY. If the timeout counter reaches 2^LOCK_TIMEOUT_LOG2−1, go to FAIL.
  - QUALIFY (2): a stable counter increments while valid&&locked. Any cycle with !locked goes to FAIL. Any cycle with !valid clears the stable counter and stays in QUALIFY. On the cycle it reaches STABLE_CYCLES−1, go to UP.
  - UP (3): link_up=1, registered and asserted the cycle state==UP.
    - The leaky bucket increments on !valid and decrements on valid, floored at 0.
    - !locked, or bucket reaching 2^LOSS_LOG2−1, goes to FAIL.
    - On entry: retry_count←0, backoff exponent←BACKOFF_MIN_LOG2, bucket←0.
  - FAIL (4): one cycle.
    - retry_count increments, saturating at 255.
    - Backoff exponent increments, saturating at BACKOFF_MAX_LOG2.
    - Go to BACKOFF.
  - BACKOFF (5): hdmi_reset=1 and the decoder is held in reset. Wait 2^exponent cycles (using the exponent before the FAIL increment), then go to RESET.
- user_reset:
  - In any state it forces RESET next cycle and clears link_up.
  - It counts as neither a failure nor a retry.
  - It has priority over every other transition.
- frame_count:
  - Increments on the synchronised vsync 1→0 edge only while state==UP.
  - Wraps 255→0.
  - Holds its value outside UP and is cleared only by reset_n.
- hdmi_reset is a registered output: 1 in RESET and BACKOFF, 0 otherwise.
- Unused encodings 6 and 7 recover to RESET.
- reset_n asserted mid-operation restores all reset values on the next edge, regardless of state.

Decomposition:
- Shared package hdmi_pkg holds:
  - state encodings (ST_RESET…ST_BACKOFF);
  - the 8-bit status widths;
  - default timing constants, so the display module and debug UART decode `state` identically.
- One natural sub-module: sync2, the 2-flop synchroniser, instantiated three times and reused by other cross-domain paths.

Test Plan:
Use small parameters: RESET_CYCLES=4, LOCK_TIMEOUT_LOG2=6, STABLE_CYCLES=8, LOSS_LOG2=4, BACKOFF_MIN_LOG2=3, BACKOFF_MAX_LOG2=5.
1. Clean bring-up: release reset_n, hold locked=valid=1. Required: hdmi_reset high exactly 4 cycles, then RESET→WAIT_LOCK→QUALIFY→UP, with link_up rising 8 qualifying cycles after QUALIFY entry plus sync latency, and retry_count=0.
2. No lock: locked=0. Required: FAIL after 64 WAIT_LOCK cycles, retry_count=1, BACKOFF lasting 8, then 16, then 32, then 32 cycles (saturated), retry_count incrementing each time.
3. Qualify glitch: drop valid for 1 cycle at stable count 5. Required: counter restarts and link_up is delayed by a further 8 cycles. Dropping locked instead gives FAIL.
4. Loss in UP: valid toggles 1/0 and the link stays UP. Valid held 0 drives the bucket to 15 (from 0) → FAIL and link_up=0 the same cycle as the FAIL state.
5. Frames: 300 vsync pulses in UP. Required: frame_count=44 (wrapped). Pulses sent in BACKOFF leave it unchanged.
6. user_reset during BACKOFF and during UP: RESET next cycle, retry_count unchanged. reset_n low mid-QUALIFY restores every reset value.
